// File: rtl/adder_pkg.sv
// Shared widths and word types for the pipelined 16-bit adder.
package adder_pkg;

  localparam int ADD_WIDTH  = 16;
  localparam int HALF_WIDTH = ADD_WIDTH / 2;

  typedef logic [ADD_WIDTH-1:0]  word_t;
  typedef logic [HALF_WIDTH-1:0] half_t;

endpackage : adder_pkg

// File: rtl/sixteen_bit_adder_if.sv
// Operand/result bundle of the pipelined adder; the master drives operands, the slave returns results.
interface sixteen_bit_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, s, cout
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, s, cout
  );

endinterface : sixteen_bit_adder_if

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder; the building block of both ripple chains.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_p;

  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & w_p);

endmodule : full_adder_cell

// File: rtl/sixteen_bit_adder.sv
// Two-stage pipelined adder: low half rippled in stage 1, high half in stage 2 off the
// registered low-half carry, so each stage is bounded by a WIDTH/2-bit ripple.
module sixteen_bit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  sixteen_bit_adder_if.slave  bus
);

  localparam int HALF = WIDTH / 2;

  if ((WIDTH % 2) != 0) begin : g_width_check
    $error("sixteen_bit_adder: WIDTH must be even");
  end

  // Stage 1 combinational: low-half ripple chain fed by cin.
  logic [HALF:0]   w_lo_c;
  logic [HALF-1:0] w_lo_sum;

  assign w_lo_c[0] = bus.cin;

  for (genvar i = 0; i < HALF; i++) begin : g_lo_chain
    full_adder_cell u_fa (
      .i_a  (bus.a[i]),
      .i_b  (bus.b[i]),
      .i_ci (w_lo_c[i]),
      .o_s  (w_lo_sum[i]),
      .o_co (w_lo_c[i+1])
    );
  end

  logic            r_s1_valid;
  logic [HALF-1:0] r_s1_lo_sum;
  logic            r_s1_lo_carry;
  logic [HALF-1:0] r_s1_a_hi;
  logic [HALF-1:0] r_s1_b_hi;

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, which is what makes the two stages behave as a pipeline.
  // NOTE: the data registers are reset along with the valid bits because s and cout
  // must read zero while rst_n is low, not just be masked by out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_lo_sum   <= '0;
      r_s1_lo_carry <= 1'b0;
      r_s1_a_hi     <= '0;
      r_s1_b_hi     <= '0;
    end else begin
      r_s1_valid    <= bus.in_valid;
      r_s1_lo_sum   <= w_lo_sum;
      r_s1_lo_carry <= w_lo_c[HALF];
      r_s1_a_hi     <= bus.a[WIDTH-1:HALF];
      r_s1_b_hi     <= bus.b[WIDTH-1:HALF];
    end
  end

  // Stage 2 combinational: high-half ripple chain fed by the registered low carry.
  logic [HALF:0]   w_hi_c;
  logic [HALF-1:0] w_hi_sum;

  assign w_hi_c[0] = r_s1_lo_carry;

  for (genvar i = 0; i < HALF; i++) begin : g_hi_chain
    full_adder_cell u_fa (
      .i_a  (r_s1_a_hi[i]),
      .i_b  (r_s1_b_hi[i]),
      .i_ci (w_hi_c[i]),
      .o_s  (w_hi_sum[i]),
      .o_co (w_hi_c[i+1])
    );
  end

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_sum;
  logic             r_s2_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_cout  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_sum   <= {w_hi_sum, r_s1_lo_sum};
      r_s2_cout  <= w_hi_c[HALF];
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.s         = r_s2_sum;
  assign bus.cout      = r_s2_cout;

endmodule : sixteen_bit_adder

// File: tb/tb_sixteen_bit_adder.sv
// Self-checking bench for sixteen_bit_adder: scoreboard of 17-bit reference sums,
// directed carry/bubble/reset cases and a random regression.
module tb_sixteen_bit_adder;
  import adder_pkg::*;

  logic clk;
  logic rst_n;

  sixteen_bit_adder_if #(.WIDTH(ADD_WIDTH)) bus ();

  sixteen_bit_adder #(.WIDTH(ADD_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] sb_q[$];
  logic [1:0]  valid_pipe = 2'b00;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one operand set, advance one clock, then check whatever the pipeline presents.
  task automatic step(input logic v, input word_t x, input word_t y, input logic c);
    logic [16:0] expected;
    logic [16:0] actual;
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
    bus.cin      = c;
    if (v) sb_q.push_back({1'b0, x} + {1'b0, y} + {16'd0, c});
    @(posedge clk);
    #1;
    valid_pipe = {valid_pipe[0], v};
    check("out_valid", 32'(bus.out_valid), 32'(valid_pipe[1]));
    if (valid_pipe[1]) begin
      expected = sb_q.pop_front();
      actual   = {bus.cout, bus.s};
      check("sum", 32'(actual), 32'(expected));
    end
  endtask

  task automatic idle_step();
    step(1'b0, word_t'($urandom), word_t'($urandom), 1'($urandom));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_s"},     32'(bus.s),         32'd0);
    check({tag, "_cout"},  32'(bus.cout),      32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    rst_n        = 1'b0;

    // Reset held for 3 cycles, then zeros.
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0);

    // Incrementing stream: a every 4 cycles, b every 2, cin toggling.
    for (int k = 0; k < 32; k++)
      step(1'b1, word_t'(k / 4), word_t'(k / 2), 1'(k % 2));
    idle_step();
    idle_step();

    // Carry boundaries.
    step(1'b1, 16'h00FF, 16'h0001, 1'b0);
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step(1'b1, 16'h7FFF, 16'h8000, 1'b1);
    idle_step();
    idle_step();

    // Back-to-back with a bubble between.
    step(1'b1, 16'h1234, 16'h1111, 1'b0);
    idle_step();
    step(1'b1, 16'h8000, 16'h8000, 1'b1);
    idle_step();
    idle_step();

    // Asynchronous reset between edges with two results in flight.
    step(1'b1, 16'hA5A5, 16'h1111, 1'b1);
    step(1'b1, 16'h0F0F, 16'h0101, 1'b0);
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset");
    sb_q.delete();
    valid_pipe = 2'b00;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle_step();

    // Random regression with random bubbles.
    for (int n = 0; n < 10000; n++)
      step(1'($urandom), word_t'($urandom), word_t'($urandom), 1'($urandom));
    idle_step();
    idle_step();

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sixteen_bit_adder

// File: doc/sixteen_bit_adder.md
Name: sixteen_bit_adder

Overview:
- Registered 16-bit binary adder with carry-in and carry-out.
- Two-stage pipeline: low byte added in stage 1, high byte in stage 2 using the registered stage-1 carry.
- Accepts one operand set per clock; a valid flag travels alongside each result.
- Datapath primitive for arithmetic blocks that need a 16-bit add with full carry visibility.

Parameters:
- WIDTH, 16: operand and sum width; must be even (split point WIDTH/2).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operands a, b, cin valid this cycle.
- a, input, WIDTH: addend A, unsigned.
- b, input, WIDTH: addend B, unsigned.
- cin, input, 1: carry-in.
- out_valid, output, 1: s and cout hold a valid result.
- s, output, WIDTH: sum, equal to (a + b + cin) mod 2^WIDTH.
- cout, output, 1: carry-out, bit WIDTH of a + b + cin.

Behaviour:
- Interface: one clock (clk), reset asynchronous and active-low (rst_n).
- Reset: rst_n low immediately clears all pipeline registers, so out_valid=0, s=0, cout=0. State stays cleared while rst_n is low; first capture happens on the first rising clk edge after release.
- Stage 1, registered on clk:
  - low-half sum = a[7:0] + b[7:0] + cin, producing lo_sum[7:0] and lo_carry.
  - a[15:8], b[15:8] and in_valid are registered alongside.
- Stage 2, registered on clk:
  - hi_sum[7:0] and cout = a_hi + b_hi + lo_carry.
  - s = {hi_sum, lo_sum}; out_valid = stage-1 valid.
- Latency: exactly 2 clk edges from input sample to output. Throughput: 1 result per cycle, no backpressure and no stall input.
- Bubbles: when in_valid=0, the data registers still capture (don't-care contents) but the valid bit propagates as 0. s and cout are defined only when out_valid=1. Verification compares only on out_valid.
- Arithmetic: unsigned modular addition; no overflow flag, no saturation.
- Wrap-around:
  - 0xFFFF + 0x0001 + 0 gives s=0x0000, cout=1.
  - 0xFFFF + 0xFFFF + 1 gives s=0xFFFF, cout=1.
- Cross-half carry: a carry generated in the low byte must ripple fully into the high byte, e.g. 0x00FF + 0x0001 gives 0x0100.
- Reset mid-operation: every in-flight result is discarded and out_valid drops asynchronously. No partial result appears after reset release.
- Adders inside each stage: ripple-carry chains of full-adder cells, no behavioural "+" on the full width. Each stage chain is 8 bits, so timing is bounded by an 8-bit ripple.

Decomposition:
- Shared package (adder_pkg):
  - ADD_WIDTH = 16 and HALF_WIDTH = 8 constants.
  - typedef word_t (logic [15:0]) and half_t (logic [7:0]).
- Sub-module full_adder_cell: 1-bit combinational full adder, s = a^b^ci, co = ab | ci(a^b). Instantiated WIDTH times via generate, in two 8-bit chains.
- Pipeline registers live in the top module.

Test Plan:
- Reset then zeros: hold rst_n=0 for 3 cycles, release, drive a=0, b=0, cin=0, in_valid=1 -> s=0x0000, cout=0, out_valid=1 exactly 2 cycles later; out_valid=0 before that.
- Incrementing stream:
  - stimulus: a increments every 4 cycles, b every 2 cycles, cin toggles every cycle, in_valid=1 throughout.
  - required: each output equals (a+b+cin) of the sample 2 cycles earlier, e.g. a=1, b=2, cin=1 -> s=0x0004, cout=0.
- Carry boundaries:
  - a=0x00FF, b=0x0001, cin=0 -> s=0x0100, cout=0.
  - a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1.
  - a=0xFFFF, b=0xFFFF, cin=1 -> s=0xFFFF, cout=1.
- Back-to-back with bubble: valid, invalid, valid sequence (0x1234+0x1111+0, then idle, then 0x8000+0x8000+1) -> out_valid pattern 1,0,1 two cycles later; results s=0x2345 cout=0, then s=0x0001 cout=1.
- Async reset mid-flight: two valid inputs issued, rst_n asserted between clk edges -> out_valid, s, cout go to 0 immediately (before next edge); no stale result after release.
- Random regression: 10,000 random a, b, cin with random in_valid -> every valid output matches the 17-bit reference sum.
